// File: rtl/priority_pkg.sv
// Shared definitions for the priority grant decoder: default line count,
// code-width helper and the grant FSM state type.
package priority_pkg;

    localparam int LINES_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic int code_w(input int lines);
        return (lines > 1) ? $clog2(lines) : 1;
    endfunction

endpackage

// File: rtl/prio_onehot_pick.sv
// Combinational pick of the highest set bit of a mask as a one-hot vector,
// plus a flag that any bit is set.
module prio_onehot_pick
    import priority_pkg::*;
#(
    parameter int LINES = LINES_DEF
) (
    input  logic [LINES-1:0] mask,
    output logic [LINES-1:0] onehot,
    output logic             any
);

    // Ascending scan: the last set bit seen, i.e. the highest, wins.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < LINES; i++) begin
            if (mask[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

    assign any = |mask;

endmodule

// File: rtl/priority_grant_decoder_8bit.sv
// Latches decoded line codes into a pending mask and offers one-hot grants to
// the highest pending line, one at a time, released by grant_ack.
//
// state | meaning
// IDLE  | no grant offered; picks highest pending line if any
// GRANT | grant held stable until grant_ack
module priority_grant_decoder_8bit
    import priority_pkg::*;
#(
    parameter  int LINES  = LINES_DEF,
    localparam int CODE_W = code_w(LINES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] code,
    input  logic              code_valid,
    output logic [LINES-1:0]  grant,
    output logic              grant_valid,
    input  logic              grant_ack,
    output logic [LINES-1:0]  pending,
    output logic              dup_err,
    output logic              range_err
);

    state_e           state_q, state_d;
    logic [LINES-1:0] pending_q, pending_d;
    logic [LINES-1:0] grant_q, grant_d;
    logic             dup_q, dup_d;
    logic             range_q, range_d;

    logic [LINES-1:0] pick_oh;
    logic             pick_any;
    logic             in_range;
    logic             ack_fire;
    logic [LINES-1:0] clr_mask;
    logic [LINES-1:0] set_mask;
    logic [LINES-1:0] kept;

    prio_onehot_pick #(.LINES(LINES)) u_pick (
        .mask   (pending_q),
        .onehot (pick_oh),
        .any    (pick_any)
    );

    // Clear of the acked line is applied before the new set, so a code that
    // re-requests the line being released is a fresh request, not a duplicate.
    always_comb begin
        in_range  = 32'(code) < LINES;
        ack_fire  = (state_q == GRANT) && grant_ack;
        clr_mask  = ack_fire ? grant_q : '0;
        set_mask  = (code_valid && in_range) ? (LINES'(1) << code) : '0;
        kept      = pending_q & ~clr_mask;
        pending_d = kept | set_mask;
        dup_d     = |(kept & set_mask);
        range_d   = code_valid && !in_range;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_any)  state_d = GRANT;
            GRANT:   if (grant_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d = grant_q;
        case (state_q)
            IDLE:    grant_d = pick_oh;
            GRANT:   if (grant_ack) grant_d = '0;
            default: grant_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            grant_q   <= '0;
            dup_q     <= 1'b0;
            range_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            grant_q   <= grant_d;
            dup_q     <= dup_d;
            range_q   <= range_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = (state_q == GRANT);
    assign pending     = pending_q;
    assign dup_err     = dup_q;
    assign range_err   = range_q;

endmodule

// File: tb/tb_priority_grant_decoder_8bit.sv
// Drives an 8-line and a 6-line decoder from one stimulus stream and compares
// both every cycle against a line-index reference model.
module tb_priority_grant_decoder_8bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       code_valid;
    logic [2:0] code;
    logic       grant_ack;

    logic [7:0] grant8, pending8;
    logic       gv8, dup8, rng8;
    logic [5:0] grant6, pending6;
    logic       gv6, dup6, rng6;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: pending lines as a bit set, granted line as an index (-1 = none).
    logic [7:0] m_pend [2];
    int         m_gl   [2];
    logic       m_dup  [2];
    logic       m_rng  [2];

    always #5 clk = ~clk;

    priority_grant_decoder_8bit u_dut8 (
        .clk         (clk),
        .rst         (rst),
        .code        (code),
        .code_valid  (code_valid),
        .grant       (grant8),
        .grant_valid (gv8),
        .grant_ack   (grant_ack),
        .pending     (pending8),
        .dup_err     (dup8),
        .range_err   (rng8)
    );

    priority_grant_decoder_8bit #(.LINES(6)) u_dut6 (
        .clk         (clk),
        .rst         (rst),
        .code        (code),
        .code_valid  (code_valid),
        .grant       (grant6),
        .grant_valid (gv6),
        .grant_ack   (grant_ack),
        .pending     (pending6),
        .dup_err     (dup6),
        .range_err   (rng6)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int highest(input logic [7:0] p);
        for (int i = 7; i >= 0; i--) begin
            if (p[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input int d);
        int         lines;
        int         ln;
        logic [7:0] p;
        lines = (d == 0) ? 8 : 6;
        if (rst) begin
            m_pend[d] = '0;
            m_gl[d]   = -1;
            m_dup[d]  = 1'b0;
            m_rng[d]  = 1'b0;
            return;
        end
        ln = int'(code);
        p  = m_pend[d];
        if (m_gl[d] >= 0 && grant_ack) p[m_gl[d]] = 1'b0;
        m_rng[d] = code_valid && (ln >= lines);
        m_dup[d] = code_valid && (ln < lines) && p[ln];
        if (m_gl[d] >= 0) begin
            if (grant_ack) m_gl[d] = -1;
        end else begin
            m_gl[d] = highest(m_pend[d]);
        end
        if (code_valid && ln < lines) p[ln] = 1'b1;
        m_pend[d] = p;
    endtask

    function automatic logic [31:0] exp_grant(input int d);
        return (m_gl[d] < 0) ? 32'd0 : (32'd1 << m_gl[d]);
    endfunction

    task automatic check_all();
        check_eq("l8_pending",   {24'd0, pending8}, {24'd0, m_pend[0]});
        check_eq("l8_grant",     {24'd0, grant8},   exp_grant(0));
        check_eq("l8_gvalid",    {31'd0, gv8},      {31'd0, m_gl[0] >= 0});
        check_eq("l8_dup_err",   {31'd0, dup8},     {31'd0, m_dup[0]});
        check_eq("l8_range_err", {31'd0, rng8},     {31'd0, m_rng[0]});
        check_eq("l6_pending",   {26'd0, pending6}, {24'd0, m_pend[1]});
        check_eq("l6_grant",     {26'd0, grant6},   exp_grant(1));
        check_eq("l6_gvalid",    {31'd0, gv6},      {31'd0, m_gl[1] >= 0});
        check_eq("l6_dup_err",   {31'd0, dup6},     {31'd0, m_dup[1]});
        check_eq("l6_range_err", {31'd0, rng6},     {31'd0, m_rng[1]});
    endtask

    task automatic cyc(input logic r, input logic cv, input logic [2:0] c, input logic a);
        rst        = r;
        code_valid = cv;
        code       = c;
        grant_ack  = a;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_all();
    endtask

    initial begin
        int         order_q [$];
        int         cyc_q   [$];
        logic [7:0] want_order [3];

        for (int d = 0; d < 2; d++) begin
            m_pend[d] = '0;
            m_gl[d]   = -1;
            m_dup[d]  = 1'b0;
            m_rng[d]  = 1'b0;
        end
        rst = 1'b1; code_valid = 1'b0; code = '0; grant_ack = 1'b0;

        // reset with a valid code present
        cyc(1, 1, 3'd3, 0);
        cyc(1, 1, 3'd3, 0);
        check_eq("t1_pending_rst", {24'd0, pending8}, 32'h0);
        check_eq("t1_gvalid_rst",  {31'd0, gv8},      32'h0);
        cyc(0, 0, 3'd0, 0);
        check_eq("t1_pending_rel", {24'd0, pending8}, 32'h0);

        // single request, latency and ack
        cyc(0, 1, 3'd5, 0);
        check_eq("t2_pending_n1", {24'd0, pending8}, 32'h20);
        check_eq("t2_grant_n1",   {24'd0, grant8},   32'h0);
        cyc(0, 0, 3'd0, 0);
        check_eq("t2_grant_n2",   {24'd0, grant8},   32'h20);
        check_eq("t2_gvalid_n2",  {31'd0, gv8},      32'h1);
        cyc(0, 0, 3'd0, 1);
        check_eq("t2_pending_ack", {24'd0, pending8}, 32'h0);
        check_eq("t2_gvalid_ack",  {31'd0, gv8},      32'h0);

        // priority order with a held grant on line 0 while 1,4,7 arrive
        cyc(0, 1, 3'd0, 0);
        cyc(0, 1, 3'd1, 0);
        cyc(0, 1, 3'd4, 0);
        cyc(0, 1, 3'd7, 0);
        check_eq("t3_hold_line0", {24'd0, grant8}, 32'h01);
        cyc(0, 0, 3'd0, 1);
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 0, 3'd0, 1);
            if (gv8) begin
                order_q.push_back(int'(grant8));
                cyc_q.push_back(i);
            end
        end
        want_order[0] = 8'h80; want_order[1] = 8'h10; want_order[2] = 8'h02;
        check_eq("t3_grant_count", order_q.size(), 32'd3);
        for (int i = 0; i < order_q.size() && i < 3; i++) begin
            check_eq("t3_grant_order", order_q[i], {24'd0, want_order[i]});
            if (i > 0) check_eq("t3_grant_spacing", cyc_q[i] - cyc_q[i-1], 32'd2);
        end
        cyc(0, 0, 3'd0, 0);

        // no preemption by a higher-priority arrival
        cyc(0, 1, 3'd4, 0);
        cyc(0, 0, 3'd0, 0);
        check_eq("t4_grant_first", {24'd0, grant8}, 32'h10);
        cyc(0, 1, 3'd6, 0);
        cyc(0, 0, 3'd0, 0);
        check_eq("t4_grant_held", {24'd0, grant8}, 32'h10);
        cyc(0, 0, 3'd0, 1);
        cyc(0, 0, 3'd0, 0);
        check_eq("t4_grant_next", {24'd0, grant8}, 32'h40);
        cyc(0, 0, 3'd0, 1);
        cyc(0, 0, 3'd0, 0);

        // duplicate detection and same-cycle ack + re-request
        cyc(0, 1, 3'd2, 0);
        check_eq("t5_dup_first", {31'd0, dup8}, 32'h0);
        cyc(0, 1, 3'd2, 0);
        check_eq("t5_dup_pulse", {31'd0, dup8}, 32'h1);
        cyc(0, 0, 3'd0, 0);
        check_eq("t5_dup_clear", {31'd0, dup8}, 32'h0);
        check_eq("t5_grant_l2",  {24'd0, grant8}, 32'h04);
        cyc(0, 1, 3'd2, 1);
        check_eq("t5_ack_reset_pend", {24'd0, pending8}, 32'h04);
        check_eq("t5_ack_reset_dup",  {31'd0, dup8},     32'h0);
        cyc(0, 0, 3'd0, 0);
        cyc(0, 0, 3'd0, 1);
        cyc(0, 0, 3'd0, 0);

        // out-of-range code on the 6-line build, then reset mid-grant
        cyc(0, 1, 3'd7, 0);
        check_eq("t6_range_pulse", {31'd0, rng6},     32'h1);
        check_eq("t6_range_pend",  {26'd0, pending6}, 32'h0);
        check_eq("t6_range_l8",    {31'd0, rng8},     32'h0);
        cyc(0, 0, 3'd0, 0);
        check_eq("t6_range_clear", {31'd0, rng6}, 32'h0);
        check_eq("t6_gvalid_pre",  {31'd0, gv8},  32'h1);
        cyc(1, 0, 3'd0, 0);
        check_eq("t6_gvalid_rst",  {31'd0, gv8},      32'h0);
        check_eq("t6_pending_rst", {24'd0, pending8}, 32'h0);
        cyc(0, 0, 3'd0, 0);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(63) == 0,
                $urandom_range(9) < 6,
                3'($urandom_range(7)),
                $urandom_range(1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
